// File: rtl/barrier_scan_ctrl.sv
// Per-frame barrier collision scanner: walks the barrier table once per frame_start and commits ORed results atomically.
// Optional macro BARRIER_HIT_INDEX_EN adds bullet_1_hit_idx/bullet_2_hit_idx (lowest enabled barrier index with a bullet hit).
module barrier_scan_ctrl #(
  parameter int NUM_BARRIERS = 8,
  parameter int IDX_W        = $clog2(NUM_BARRIERS)
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    frame_start,
  input  logic [NUM_BARRIERS-1:0] barrier_en,
  output logic [IDX_W-1:0]        barrier_sel,
  input  logic [3:0]              p1_coll_in,
  input  logic [3:0]              p2_coll_in,
  input  logic                    b1_coll_in,
  input  logic                    b2_coll_in,
  output logic [3:0]              player_1_collision,
  output logic [3:0]              player_2_collision,
  output logic                    bullet_1_collision,
  output logic                    bullet_2_collision,
`ifdef BARRIER_HIT_INDEX_EN
  output logic [IDX_W-1:0]        bullet_1_hit_idx,
  output logic [IDX_W-1:0]        bullet_2_hit_idx,
`endif
  output logic                    result_valid,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BARRIERS - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IDX_W-1:0]        r_sel;
  logic [IDX_W-1:0]        r_prev_idx;
  logic                    r_prev_vld;
  logic [NUM_BARRIERS-1:0] r_mask;
  logic [3:0]              r_p1_acc, r_p2_acc;
  logic                    r_b1_acc, r_b2_acc;
  logic [3:0]              r_p1_out, r_p2_out;
  logic                    r_b1_out, r_b2_out;
  logic                    r_valid;
  logic                    r_overrun;
  logic                    w_take;
  logic [3:0]              w_p1_nxt, w_p2_nxt;
  logic                    w_b1_nxt, w_b2_nxt;

  // Checker results lag barrier_sel by one cycle, so they are qualified by the delayed index.
  assign w_take   = ((r_state == SCAN && r_prev_vld) || r_state == DRAIN) && r_mask[r_prev_idx];
  assign w_p1_nxt = r_p1_acc | (w_take ? p1_coll_in : 4'b0000);
  assign w_p2_nxt = r_p2_acc | (w_take ? p2_coll_in : 4'b0000);
  assign w_b1_nxt = r_b1_acc | (w_take & b1_coll_in);
  assign w_b2_nxt = r_b2_acc | (w_take & b2_coll_in);

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (frame_start) w_state_nxt = SCAN;
      SCAN:    if (r_sel == LAST_IDX) w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      r_sel      <= '0;
      r_prev_idx <= '0;
      r_prev_vld <= 1'b0;
      r_mask     <= '0;
      r_p1_acc   <= '0;
      r_p2_acc   <= '0;
      r_b1_acc   <= 1'b0;
      r_b2_acc   <= 1'b0;
      r_p1_out   <= '0;
      r_p2_out   <= '0;
      r_b1_out   <= 1'b0;
      r_b2_out   <= 1'b0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (frame_start && r_state != IDLE) r_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_sel      <= '0;
            r_prev_vld <= 1'b0;
            r_mask     <= barrier_en;
            r_p1_acc   <= '0;
            r_p2_acc   <= '0;
            r_b1_acc   <= 1'b0;
            r_b2_acc   <= 1'b0;
          end
        end
        SCAN: begin
          if (r_sel != LAST_IDX) r_sel <= r_sel + IDX_W'(1);
          r_prev_idx <= r_sel;
          r_prev_vld <= 1'b1;
          r_p1_acc   <= w_p1_nxt;
          r_p2_acc   <= w_p2_nxt;
          r_b1_acc   <= w_b1_nxt;
          r_b2_acc   <= w_b2_nxt;
        end
        DRAIN: begin
          r_prev_vld <= 1'b0;
          r_p1_out   <= w_p1_nxt;
          r_p2_out   <= w_p2_nxt;
          r_b1_out   <= w_b1_nxt;
          r_b2_out   <= w_b2_nxt;
          r_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BARRIER_HIT_INDEX_EN
  logic [IDX_W-1:0] r_b1_idx_acc, r_b2_idx_acc;
  logic [IDX_W-1:0] r_b1_idx_out, r_b2_idx_out;
  logic [IDX_W-1:0] w_b1_idx_nxt, w_b2_idx_nxt;

  // Indices are scanned in ascending order, so the first hit seen is the lowest.
  assign w_b1_idx_nxt = (w_take && b1_coll_in && !r_b1_acc) ? r_prev_idx : r_b1_idx_acc;
  assign w_b2_idx_nxt = (w_take && b2_coll_in && !r_b2_acc) ? r_prev_idx : r_b2_idx_acc;

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      r_b1_idx_acc <= '0;
      r_b2_idx_acc <= '0;
      r_b1_idx_out <= '0;
      r_b2_idx_out <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_b1_idx_acc <= '0;
            r_b2_idx_acc <= '0;
          end
        end
        SCAN: begin
          r_b1_idx_acc <= w_b1_idx_nxt;
          r_b2_idx_acc <= w_b2_idx_nxt;
        end
        DRAIN: begin
          r_b1_idx_out <= w_b1_idx_nxt;
          r_b2_idx_out <= w_b2_idx_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bullet_1_hit_idx = r_b1_idx_out;
  assign bullet_2_hit_idx = r_b2_idx_out;
`endif

  assign barrier_sel        = r_sel;
  assign player_1_collision = r_p1_out;
  assign player_2_collision = r_p2_out;
  assign bullet_1_collision = r_b1_out;
  assign bullet_2_collision = r_b2_out;
  assign result_valid       = r_valid;
  assign busy               = (r_state != IDLE);
  assign overrun            = r_overrun;

endmodule

// File: tb/tb_barrier_scan_ctrl.sv
// Directed, table-driven bench for barrier_scan_ctrl (NUM_BARRIERS=8), plus overrun and mid-scan reset sequences.
module tb_barrier_scan_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       frame_start;
  logic [7:0] barrier_en;
  logic [2:0] barrier_sel;
  logic [3:0] p1_coll_in, p2_coll_in;
  logic       b1_coll_in, b2_coll_in;
  logic [3:0] player_1_collision, player_2_collision;
  logic       bullet_1_collision, bullet_2_collision;
  logic       result_valid, busy, overrun;
`ifdef BARRIER_HIT_INDEX_EN
  logic [2:0] bullet_1_hit_idx, bullet_2_hit_idx;
`endif

  barrier_scan_ctrl #(.NUM_BARRIERS(8)) dut (
    .frame_clk          (frame_clk),
    .Reset              (Reset),
    .frame_start        (frame_start),
    .barrier_en         (barrier_en),
    .barrier_sel        (barrier_sel),
    .p1_coll_in         (p1_coll_in),
    .p2_coll_in         (p2_coll_in),
    .b1_coll_in         (b1_coll_in),
    .b2_coll_in         (b2_coll_in),
    .player_1_collision (player_1_collision),
    .player_2_collision (player_2_collision),
    .bullet_1_collision (bullet_1_collision),
    .bullet_2_collision (bullet_2_collision),
`ifdef BARRIER_HIT_INDEX_EN
    .bullet_1_hit_idx   (bullet_1_hit_idx),
    .bullet_2_hit_idx   (bullet_2_hit_idx),
`endif
    .result_valid       (result_valid),
    .busy               (busy),
    .overrun            (overrun)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [7:0]      en;
    logic [7:0][3:0] p1;
    logic [7:0][3:0] p2;
    logic [7:0]      b1;
    logic [7:0]      b2;
    logic [3:0]      exp_p1;
    logic [3:0]      exp_p2;
    logic            exp_b1;
    logic            exp_b2;
    logic [2:0]      exp_b1i;
    logic [2:0]      exp_b2i;
  } vec_t;

  vec_t vecs [0:5];
  int   n_checks = 0;
  int   n_errors = 0;
  logic [3:0] pv_p1, pv_p2;
  logic       pv_b1, pv_b2;
  logic [2:0] pv_b1i, pv_b2i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_ins();
    p1_coll_in = '0;
    p2_coll_in = '0;
    b1_coll_in = 1'b0;
    b2_coll_in = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] e_p1, input logic [3:0] e_p2,
                               input logic e_b1, input logic e_b2, input logic [2:0] e_b1i,
                               input logic [2:0] e_b2i);
    check({tag, "_p1"}, 32'(player_1_collision), 32'(e_p1));
    check({tag, "_p2"}, 32'(player_2_collision), 32'(e_p2));
    check({tag, "_b1"}, 32'(bullet_1_collision), 32'(e_b1));
    check({tag, "_b2"}, 32'(bullet_2_collision), 32'(e_b2));
`ifdef BARRIER_HIT_INDEX_EN
    check({tag, "_b1idx"}, 32'(bullet_1_hit_idx), 32'(e_b1i));
    check({tag, "_b2idx"}, 32'(bullet_2_hit_idx), 32'(e_b2i));
`else
    if (e_b1i === 3'bxxx || e_b2i === 3'bxxx) $display("note: unexpected X in index expectation");
`endif
  endtask

  // Cycle k after the frame_start edge: barrier_sel=k-1 for k=1..8, DRAIN at k=9, result_valid at k=10.
  task automatic run_scan(input int v);
    @(posedge frame_clk); #1;
    frame_start = 1'b1;
    barrier_en  = vecs[v].en;
    clear_ins();
    for (int k = 1; k <= 10; k++) begin
      @(posedge frame_clk); #1;
      frame_start = 1'b0;
      barrier_en  = ~vecs[v].en;
      clear_ins();
      if (k >= 2 && k <= 9) begin
        p1_coll_in = vecs[v].p1[k-2];
        p2_coll_in = vecs[v].p2[k-2];
        b1_coll_in = vecs[v].b1[k-2];
        b2_coll_in = vecs[v].b2[k-2];
      end
      @(negedge frame_clk);
      if (k <= 8) check($sformatf("v%0d_sel_k%0d", v, k), 32'(barrier_sel), 32'(k - 1));
      check($sformatf("v%0d_busy_k%0d", v, k), 32'(busy), 32'(k <= 9));
      check($sformatf("v%0d_rvalid_k%0d", v, k), 32'(result_valid), 32'(k == 10));
      if (k == 9) check_outputs($sformatf("v%0d_hold", v), pv_p1, pv_p2, pv_b1, pv_b2, pv_b1i, pv_b2i);
      if (k == 10) begin
        check_outputs($sformatf("v%0d_commit", v), vecs[v].exp_p1, vecs[v].exp_p2, vecs[v].exp_b1,
                      vecs[v].exp_b2, vecs[v].exp_b1i, vecs[v].exp_b2i);
        pv_p1 = vecs[v].exp_p1;   pv_p2 = vecs[v].exp_p2;
        pv_b1 = vecs[v].exp_b1;   pv_b2 = vecs[v].exp_b2;
        pv_b1i = vecs[v].exp_b1i; pv_b2i = vecs[v].exp_b2i;
      end
    end
  endtask

  task automatic zero_prev();
    pv_p1 = '0; pv_p2 = '0; pv_b1 = 1'b0; pv_b2 = 1'b0; pv_b1i = '0; pv_b2i = '0;
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      vecs[i].en = 8'hFF;
      vecs[i].p1 = '0; vecs[i].p2 = '0; vecs[i].b1 = '0; vecs[i].b2 = '0;
      vecs[i].exp_p1 = '0; vecs[i].exp_p2 = '0; vecs[i].exp_b1 = 1'b0; vecs[i].exp_b2 = 1'b0;
      vecs[i].exp_b1i = '0; vecs[i].exp_b2i = '0;
    end
    // v1: hits on barriers 2 and 5
    vecs[1].p1[2] = 4'b0001; vecs[1].p1[5] = 4'b0100; vecs[1].exp_p1 = 4'b0101;
    // v2: barrier 5 masked, bullet 2 only on the drain sample
    vecs[2].en = 8'hDF;
    vecs[2].p1[2] = 4'b0001; vecs[2].p1[5] = 4'b0100; vecs[2].b2[7] = 1'b1;
    vecs[2].exp_p1 = 4'b0001; vecs[2].exp_b2 = 1'b1; vecs[2].exp_b2i = 3'd7;
    // v3: player 2 on first and last barrier, bullet 1 on 3 and 6
    vecs[3].p2[0] = 4'b1000; vecs[3].p2[7] = 4'b0010; vecs[3].b1[3] = 1'b1; vecs[3].b1[6] = 1'b1;
    vecs[3].exp_p2 = 4'b1010; vecs[3].exp_b1 = 1'b1; vecs[3].exp_b1i = 3'd3;
    // v4: everything masked
    vecs[4].en = 8'h00;
    vecs[4].p1 = {8{4'b1111}}; vecs[4].p2 = {8{4'b1111}}; vecs[4].b1 = 8'hFF; vecs[4].b2 = 8'hFF;
    // v5: barrier 0 masked
    vecs[5].en = 8'hFE;
    vecs[5].p1[0] = 4'b1111; vecs[5].b1 = 8'hFF; vecs[5].b2[0] = 1'b1; vecs[5].b2[4] = 1'b1;
    vecs[5].exp_b1 = 1'b1; vecs[5].exp_b1i = 3'd1; vecs[5].exp_b2 = 1'b1; vecs[5].exp_b2i = 3'd4;

    Reset = 1'b0; frame_start = 1'b0; barrier_en = '0; clear_ins(); zero_prev();
    repeat (3) @(posedge frame_clk);
    @(negedge frame_clk);
    check("rst_sel", 32'(barrier_sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rvalid", 32'(result_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check_outputs("rst", '0, '0, 1'b0, 1'b0, '0, '0);
    @(posedge frame_clk); #1;
    Reset = 1'b1;

    for (int v = 0; v < 6; v++) run_scan(v);

    // Overrun: extra frame_start mid-scan, then a new scan accepted in the result_valid cycle.
    @(posedge frame_clk); #1;
    frame_start = 1'b1; barrier_en = 8'hFF; clear_ins();
    @(negedge frame_clk);
    check("ovr_before", 32'(overrun), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge frame_clk); #1;
      frame_start = (k == 3 || k == 10);
      @(negedge frame_clk);
      if (k >= 4) check($sformatf("ovr_sticky_k%0d", k), 32'(overrun), 32'd1);
      check($sformatf("ovr_rvalid_k%0d", k), 32'(result_valid), 32'(k == 10 || k == 20));
      if (k == 5) check("ovr_sel_k5", 32'(barrier_sel), 32'd4);
      if (k == 11) begin
        check("ovr_resel", 32'(barrier_sel), 32'd0);
        check("ovr_rebusy", 32'(busy), 32'd1);
      end
      if (k == 20) check_outputs("ovr_commit", '0, '0, 1'b0, 1'b0, '0, '0);
    end
    zero_prev();

    // Mid-scan reset after a hit on barrier 1; previous committed results (v5) are nonzero.
    run_scan(5);
    @(posedge frame_clk); #1;
    frame_start = 1'b1; barrier_en = 8'hFF; clear_ins();
    for (int k = 1; k <= 5; k++) begin
      @(posedge frame_clk); #1;
      frame_start = 1'b0; clear_ins();
      if (k == 3) begin p1_coll_in = 4'b0010; b1_coll_in = 1'b1; end
    end
    Reset = 1'b0;
    #1;
    check("mrst_sel", 32'(barrier_sel), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_rvalid", 32'(result_valid), 32'd0);
    check("mrst_overrun", 32'(overrun), 32'd0);
    check_outputs("mrst", '0, '0, 1'b0, 1'b0, '0, '0);
    @(posedge frame_clk); #1;
    Reset = 1'b1;
    begin
      logic seen_rv;
      seen_rv = 1'b0;
      for (int k = 0; k < 12; k++) begin
        @(negedge frame_clk);
        seen_rv = seen_rv | result_valid;
      end
      check("mrst_no_rvalid", 32'(seen_rv), 32'd0);
    end
    zero_prev();
    run_scan(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/barrier_scan_ctrl.md
# barrier_scan_ctrl

Time-multiplexes a single registered-read barrier table and its combinational collision checker across all barriers on the playfield, once per frame. On a frame-start pulse it walks barrier indices 0..NUM_BARRIERS-1 and ORs the per-barrier tank and bullet collision results into per-frame accumulators. It then commits them atomically to registered outputs consumed by the tank and bullet motion logic. It sits between the frame timing logic, the barrier position table and the barrier collision checker.

## Interface
- NUM_BARRIERS, 8, number of barrier table entries scanned per frame (2..64)
- IDX_W, $clog2(NUM_BARRIERS), width of the barrier index
- frame_clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset (0 = reset)
- frame_start  in  1  one-cycle pulse requesting a scan
- barrier_en  in  NUM_BARRIERS  per-barrier enable mask, sampled when a scan is accepted
- barrier_sel  out  IDX_W  index presented to the barrier table
- p1_coll_in, p2_coll_in  in  4  checker tank results for the barrier selected one cycle earlier (0001 left, 0010 right, 0100 top, 1000 bottom)
- b1_coll_in, b2_coll_in  in  1  checker bullet results, same alignment
- player_1_collision, player_2_collision  out  4  committed per-frame OR of tank results
- bullet_1_collision, bullet_2_collision  out  1  committed per-frame OR of bullet results
- result_valid  out  1  one-cycle pulse: committed outputs were updated
- busy  out  1  scan in progress
- overrun  out  1  sticky: frame_start arrived while busy

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE: frame_start=1 → SCAN. Same edge: barrier_sel←0, accumulators←0, enable mask latched from barrier_en.
- SCAN: each cycle barrier_sel increments. When barrier_sel=NUM_BARRIERS-1 → DRAIN; barrier_sel holds.
- Result sampling: every SCAN cycle after the first, and the DRAIN cycle, sample the *_coll_in inputs. They belong to the previous cycle's barrier_sel (tracked by an internal delayed index plus a valid bit). Sampled values are ORed into the accumulators only if the latched mask bit for that index is 1. Otherwise they are discarded.
- DRAIN: samples index NUM_BARRIERS-1 → IDLE. Same edge: all four collision outputs←accumulator values, including the final sample. result_valid registered 1 for the following cycle.
- Committed outputs hold until the next commit. They never show partial scan results.
- frame_start while in SCAN or DRAIN: ignored, overrun←1. The scan continues unaffected. overrun clears only on reset.
- frame_start during the result_valid cycle (state IDLE) is accepted normally.
- Barrier_sel in IDLE holds its last value.

## Timing
- Reset (Reset=0, asynchronous): state IDLE. barrier_sel=0, all collision outputs=0, result_valid=0, busy=0, overrun=0, accumulators=0, mask=0.
- Reset mid-scan: the scan is aborted and no commit occurs.
- frame_start sampled at edge t0. barrier_sel = k during cycle t0+1+k. DRAIN during cycle t0+NUM_BARRIERS+1. result_valid high during cycle t0+NUM_BARRIERS+2.
- Scan latency: NUM_BARRIERS+2 cycles (10 for default).
- busy=1 in SCAN and DRAIN, which is NUM_BARRIERS+1 cycles. busy=0 in the result_valid cycle.
- Minimum frame_start spacing without overrun: NUM_BARRIERS+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- BARRIER_HIT_INDEX_EN defined: adds outputs bullet_1_hit_idx and bullet_2_hit_idx (IDX_W each).
  - Each reports the lowest enabled barrier index whose bullet result was 1 in the scan.
  - The value is committed with the other outputs and is 0 when no hit occurred.
  - Reset value is 0.
- Not defined: the ports and their tracking logic are absent. All other behaviour is identical.

## Test plan
- Reset release, NUM_BARRIERS=8, frame_start at t0, all checker inputs 0, barrier_en=8'hFF → barrier_sel 0..7 on cycles t0+1..t0+8. busy high t0+1..t0+9. result_valid only at t0+10. All collision outputs 0.
- p1_coll_in=0001 in the cycle after barrier_sel=2, and p1_coll_in=0100 in the cycle after barrier_sel=5 → player_1_collision=0101 at t0+10. Value unchanged at t0+9.
- Same stimulus with barrier_en=8'hDF (barrier 5 masked) → player_1_collision=0001. b2_coll_in=1 only on index 7 (DRAIN sample) → bullet_2_collision=1. With BARRIER_HIT_INDEX_EN, bullet_2_hit_idx=7.
- Second frame_start at t0+4 → overrun=1 and stays 1. result_valid still at t0+10 only. frame_start at t0+10 is accepted, with its result_valid at t0+20.
- Reset=0 asserted at t0+5 after a hit on index 1 → outputs immediately 0, state IDLE. No result_valid follows. The next scan starts cleanly from barrier_sel=0.
